// File: rtl/adc_udp_packetizer_pkg.sv
// Shared Ethernet/UDP definitions for the ADC packetizer: FSM state encoding
// and fixed UDP payload geometry.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_SEQ_HI  = 3'd2,
    ST_SEQ_LO  = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_DATA_LO = 3'd5
  } pkt_state_e;

  localparam int unsigned UDP_PAYLOAD_BYTES = 1024;
  localparam logic [15:0] UDP_LENGTH        = 16'h0408;

endpackage

// File: rtl/adc_udp_packetizer_if.sv
// ADC sample input plus UDP header/payload handshakes; master is the packetizer.
interface adc_udp_packetizer_if;
  logic [15:0] adc_tdata;
  logic        adc_tvalid;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready;
  logic [7:0]  m_udp_payload_axis_tdata;
  logic        m_udp_payload_axis_tvalid;
  logic        m_udp_payload_axis_tready;
  logic        m_udp_payload_axis_tlast;
  logic        m_udp_payload_axis_tuser;

  modport master (
    input  adc_tdata, adc_tvalid, m_udp_hdr_ready, m_udp_payload_axis_tready,
    output m_udp_hdr_valid, m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
           m_udp_payload_axis_tlast, m_udp_payload_axis_tuser
  );

  modport slave (
    output adc_tdata, adc_tvalid, m_udp_hdr_ready, m_udp_payload_axis_tready,
    input  m_udp_hdr_valid, m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
           m_udp_payload_axis_tlast, m_udp_payload_axis_tuser
  );
endinterface

// File: rtl/adc_udp_packetizer_fifo.sv
// Synchronous first-word-fall-through 16-bit sample FIFO. o_data_nxt exposes the
// entry behind the head so a consumer can register the post-pop head in the pop cycle.
module sample_fifo #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [15:0]           i_data,
  output logic [15:0]           o_data,
  output logic [15:0]           o_data_nxt,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [15:0]           r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full     = (r_count == DEPTH);
  assign o_empty    = (r_count == {(ADDR_WIDTH+1){1'b0}});
  assign o_count    = r_count;
  assign o_data     = r_mem[r_rd_ptr];
  assign o_data_nxt = r_mem[r_rd_ptr + PTR_ONE];
  assign w_do_pop   = i_pop && !o_empty;
  // A push into a full FIFO is accepted only when a pop frees the head slot this cycle
  assign w_do_push  = i_push && (!o_full || w_do_pop);

  // Sample storage; contents are meaningless while empty so it is not reset
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Read/write pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr <= {ADDR_WIDTH{1'b0}};
      r_count  <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/adc_udp_packetizer.sv
// Packs a continuous 16-bit ADC stream into UDP payloads: a 16-bit sequence number
// followed by SAMPLES_PER_PKT big-endian samples, all outputs registered.
module adc_udp_packetizer
  import eth_pkg::*;
#(
  parameter int SAMPLES_PER_PKT = 511,
  parameter int FIFO_ADDR_WIDTH = 10
) (
  input  logic                    i_logic_clk,
  input  logic                    i_logic_rst_n,
  input  logic                    i_enable,
  adc_udp_packetizer_if.master    udp,
  output logic                    o_fifo_overflow,
  output logic [31:0]             o_pkt_count,
  output logic                    o_busy
);
  localparam int                     IDX_W    = $clog2(SAMPLES_PER_PKT + 1);
  localparam logic [IDX_W-1:0]       IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(SAMPLES_PER_PKT);
  localparam logic [FIFO_ADDR_WIDTH:0] CNT_PKT = (FIFO_ADDR_WIDTH+1)'(SAMPLES_PER_PKT);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_HDR     = ST_HDR;
  localparam logic [2:0] S_SEQ_HI  = ST_SEQ_HI;
  localparam logic [2:0] S_SEQ_LO  = ST_SEQ_LO;
  localparam logic [2:0] S_DATA_HI = ST_DATA_HI;
  localparam logic [2:0] S_DATA_LO = ST_DATA_LO;

  logic [2:0]               r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_idx, w_idx_nxt;
  logic [7:0]               r_tdata, w_tdata_nxt;
  logic [15:0]              r_seq;
  logic [31:0]              r_pkt_count;
  logic                     r_tvalid, r_tlast, r_hdr_valid, r_busy, r_overflow;
  logic [15:0]              w_fifo_data, w_fifo_data_nxt;
  logic [FIFO_ADDR_WIDTH:0] w_fifo_count;
  logic                     w_fifo_full, w_fifo_empty;
  logic                     w_push, w_pop, w_byte_hs, w_pkt_done;

  assign w_push     = udp.adc_tvalid && i_enable;
  assign w_byte_hs  = r_tvalid && udp.m_udp_payload_axis_tready;
  assign w_pop      = (r_state == S_DATA_LO) && w_byte_hs && !w_fifo_empty;
  assign w_pkt_done = (r_state == S_DATA_LO) && w_byte_hs && r_tlast;

  sample_fifo #(.ADDR_WIDTH(FIFO_ADDR_WIDTH)) u_fifo (
    .i_clk      (i_logic_clk),
    .i_rst_n    (i_logic_rst_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_data     (udp.adc_tdata),
    .o_data     (w_fifo_data),
    .o_data_nxt (w_fifo_data_nxt),
    .o_count    (w_fifo_count),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // Next state, next payload byte and sample index; tdata is precomputed so it can be registered
  always_comb begin
    w_state_nxt = r_state;
    w_tdata_nxt = r_tdata;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_enable && (w_fifo_count >= CNT_PKT)) begin
          w_state_nxt = S_HDR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HDR: begin
        if (udp.m_udp_hdr_ready) begin
          w_state_nxt = S_SEQ_HI;
          w_tdata_nxt = r_seq[15:8];
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_SEQ_HI: begin
        if (w_byte_hs) begin
          w_state_nxt = S_SEQ_LO;
          w_tdata_nxt = r_seq[7:0];
        end else begin
          w_state_nxt = S_SEQ_HI;
        end
      end
      S_SEQ_LO: begin
        if (w_byte_hs) begin
          w_state_nxt = S_DATA_HI;
          w_tdata_nxt = w_fifo_data[15:8];
          w_idx_nxt   = IDX_ONE;
        end else begin
          w_state_nxt = S_SEQ_LO;
        end
      end
      S_DATA_HI: begin
        if (w_byte_hs) begin
          w_state_nxt = S_DATA_LO;
          w_tdata_nxt = w_fifo_data[7:0];
        end else begin
          w_state_nxt = S_DATA_HI;
        end
      end
      S_DATA_LO: begin
        if (w_byte_hs && r_tlast) begin
          w_state_nxt = S_IDLE;
          w_tdata_nxt = 8'h00;
        end else if (w_byte_hs) begin
          // The head is popped on this edge, so the next byte comes from the entry behind it
          w_state_nxt = S_DATA_HI;
          w_tdata_nxt = w_fifo_data_nxt[15:8];
          w_idx_nxt   = r_idx + IDX_ONE;
        end else begin
          w_state_nxt = S_DATA_LO;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tdata_nxt = 8'h00;
      end
    endcase
  end

  // State, registered outputs, sequence number, packet counter and sticky overflow
  always_ff @(posedge i_logic_clk or negedge i_logic_rst_n) begin
    if (!i_logic_rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= {IDX_W{1'b0}};
      r_tdata     <= 8'h00;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_seq       <= 16'h0000;
      r_pkt_count <= 32'h0000_0000;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_tdata     <= w_tdata_nxt;
      r_tvalid    <= (w_state_nxt == S_SEQ_HI) || (w_state_nxt == S_SEQ_LO) ||
                     (w_state_nxt == S_DATA_HI) || (w_state_nxt == S_DATA_LO);
      r_tlast     <= (w_state_nxt == S_DATA_LO) && (w_idx_nxt == IDX_LAST);
      r_hdr_valid <= (w_state_nxt == S_HDR);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_pkt_done) begin
        r_seq       <= r_seq + 16'h0001;
        r_pkt_count <= r_pkt_count + 32'h0000_0001;
      end
      if (w_push && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign udp.m_udp_hdr_valid           = r_hdr_valid;
  assign udp.m_udp_payload_axis_tdata  = r_tdata;
  assign udp.m_udp_payload_axis_tvalid = r_tvalid;
  assign udp.m_udp_payload_axis_tlast  = r_tlast;
  assign udp.m_udp_payload_axis_tuser  = 1'b0;
  assign o_fifo_overflow               = r_overflow;
  assign o_pkt_count                   = r_pkt_count;
  assign o_busy                        = r_busy;
endmodule

// File: tb/tb_adc_udp_packetizer.sv
// Randomised bench for adc_udp_packetizer: a transaction-level model (sample queue,
// packet phase, byte position) is compared against the DUT on every cycle.
module tb_adc_udp_packetizer;
  localparam int N     = 511;
  localparam int DEPTH = 1024;
  localparam int PB    = 2 + 2 * N;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_overflow, busy;
  logic [31:0] pkt_count;

  adc_udp_packetizer_if bus ();

  adc_udp_packetizer #(.SAMPLES_PER_PKT(N), .FIFO_ADDR_WIDTH(10)) dut (
    .i_logic_clk     (clk),
    .i_logic_rst_n   (rst_n),
    .i_enable        (enable),
    .udp             (bus),
    .o_fifo_overflow (fifo_overflow),
    .o_pkt_count     (pkt_count),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // stimulus modes
  int tv_mode  = 0;   // 0 off, 1 every cycle, 2 random 25%, 3 every other cycle
  int tr_mode  = 1;   // 0 low, 1 high, 2 random 50%
  int hr_mode  = 0;   // 0 always ready, 1 ready after 5 cycles of hdr_valid
  int ramp     = 0;
  int tv_limit = 1000000;

  // model state
  int          mq[$];
  int          m_phase = 0;  // 0 idle, 1 header, 2 payload
  int          m_k     = 0;
  logic [15:0] m_seq   = 16'h0000;
  logic [31:0] m_pkt   = 32'h0;
  logic        m_ovf   = 1'b0;
  logic [8:0]  cap_q[$];

  initial begin : drv
    bit v, prev_v;
    int hv_cnt;
    hv_cnt = 0; prev_v = 0;
    bus.adc_tvalid = 1'b0; bus.adc_tdata = 16'h0;
    bus.m_udp_hdr_ready = 1'b0; bus.m_udp_payload_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tv_mode)
        1: v = 1;
        2: v = ($urandom_range(0, 3) == 0);
        3: v = !prev_v;
        default: v = 0;
      endcase
      if (ramp >= tv_limit) v = 0;
      prev_v = v;
      bus.adc_tvalid = v;
      bus.adc_tdata  = ramp[15:0];
      if (v) ramp++;
      case (tr_mode)
        0: bus.m_udp_payload_axis_tready = 1'b0;
        2: bus.m_udp_payload_axis_tready = ($urandom_range(0, 1) == 1);
        default: bus.m_udp_payload_axis_tready = 1'b1;
      endcase
      hv_cnt = bus.m_udp_hdr_valid ? hv_cnt + 1 : 0;
      bus.m_udp_hdr_ready = (hr_mode == 0) ? 1'b1 : (hv_cnt >= 5);
    end
  end

  // Reference model: check outputs, then advance by what the coming clock edge does
  always @(negedge clk) begin : mdl
    logic [7:0]  exp_b;
    logic [15:0] smp;
    bit          pop;
    int          sz;
    if (!rst_n) begin
      mq.delete(); m_phase = 0; m_k = 0; m_seq = 16'h0; m_pkt = 32'h0; m_ovf = 1'b0;
    end else begin
      check("hdr_valid", bus.m_udp_hdr_valid, m_phase == 1);
      check("tvalid", bus.m_udp_payload_axis_tvalid, m_phase == 2);
      check("busy", busy, m_phase != 0);
      check("tuser", bus.m_udp_payload_axis_tuser, 0);
      check("overflow", fifo_overflow, m_ovf);
      check("pkt_count", pkt_count, m_pkt);
      check("tlast", bus.m_udp_payload_axis_tlast, (m_phase == 2) && (m_k == PB - 1));
      if (m_phase == 2) begin
        if (m_k == 0) exp_b = m_seq[15:8];
        else if (m_k == 1) exp_b = m_seq[7:0];
        else begin
          smp   = (mq.size() > 0) ? mq[0][15:0] : 16'h0;
          exp_b = (m_k % 2 == 0) ? smp[15:8] : smp[7:0];
        end
        check("tdata", bus.m_udp_payload_axis_tdata, exp_b);
      end
      sz = mq.size(); pop = 0;
      case (m_phase)
        0: if (enable && sz >= N) m_phase = 1;
        1: if (bus.m_udp_hdr_ready) begin m_phase = 2; m_k = 0; end
        default: if (bus.m_udp_payload_axis_tready) begin
          cap_q.push_back({bus.m_udp_payload_axis_tlast, bus.m_udp_payload_axis_tdata});
          if (m_k >= 3 && m_k % 2 == 1) pop = 1;
          if (m_k == PB - 1) begin m_phase = 0; m_seq++; m_pkt++; end
          else m_k++;
        end
      endcase
      if (pop && mq.size() > 0) void'(mq.pop_front());
      if (bus.adc_tvalid && enable) begin
        if (sz < DEPTH || pop) mq.push_back(int'(bus.adc_tdata));
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic cap_chk(input string name, input int idx, input logic [8:0] exp);
    if (idx < cap_q.size()) check(name, {23'h0, cap_q[idx]}, {23'h0, exp});
    else check(name, 32'hDEAD_BEEF, {23'h0, exp});
  endtask

  task automatic tlast_total(input string name, input int exp);
    int t;
    t = 0;
    foreach (cap_q[i]) if (cap_q[i][8]) t++;
    check(name, t, exp);
  endtask

  task automatic wait_pkt(input logic [31:0] target, input int budget, input string name);
    int i;
    i = 0;
    while (pkt_count < target && i < budget) begin @(posedge clk); #1; i++; end
    check(name, pkt_count >= target, 1'b1);
  endtask

  task automatic wait_byte(input int k, input logic [31:0] pkt, input int budget, input string name);
    int i;
    i = 0;
    while (!(m_phase == 2 && m_k == k && m_pkt == pkt) && i < budget) begin @(negedge clk); #1; i++; end
    check(name, (m_phase == 2 && m_k == k), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; tv_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    ramp = 0; cap_q.delete(); rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int hv;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_hdr_valid", bus.m_udp_hdr_valid, 0);
    check("rst_tvalid", bus.m_udp_payload_axis_tvalid, 0);
    check("rst_tlast", bus.m_udp_payload_axis_tlast, 0);
    check("rst_tdata", bus.m_udp_payload_axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_overflow", fifo_overflow, 0);

    // ramp, three back-to-back packets
    ramp = 0; tv_limit = 3 * N; cap_q.delete();
    rst_n = 1'b1; enable = 1'b1; tv_mode = 1;
    repeat (600) @(posedge clk);
    #2 tv_mode = 3;
    wait_pkt(3, 8000, "A_three_packets");
    check("A_bytes", cap_q.size(), 3 * PB);
    cap_chk("A_b0", 0, 9'h000);    cap_chk("A_b1", 1, 9'h000);
    cap_chk("A_b2", 2, 9'h000);    cap_chk("A_b3", 3, 9'h000);
    cap_chk("A_b4", 4, 9'h000);    cap_chk("A_b5", 5, 9'h001);
    cap_chk("A_b7", 7, 9'h002);    cap_chk("A_b1022", 1022, 9'h001);
    cap_chk("A_b1023", 1023, 9'h1FE);
    cap_chk("A_seq1_hi", 1024, 9'h000); cap_chk("A_seq1_lo", 1025, 9'h001);
    cap_chk("A_p2_s0_hi", 1026, 9'h001); cap_chk("A_p2_s0_lo", 1027, 9'h0FF);
    cap_chk("A_seq2_lo", 2049, 9'h002);
    cap_chk("A_p3_s0_hi", 2050, 9'h003); cap_chk("A_p3_s0_lo", 2051, 9'h0FE);
    cap_chk("A_p3_last", 3071, 9'h1FC); cap_chk("A_p3_last_hi", 3070, 9'h005);
    tlast_total("A_tlast_count", 3);
    check("A_overflow", fifo_overflow, 0);

    // random backpressure and a delayed header acceptance
    do_reset();
    tv_limit = 1000000; tr_mode = 2; hr_mode = 1; tv_mode = 2;
    wait_pkt(1, 20000, "B_packet");
    cap_chk("B_b0", 0, 9'h000);   cap_chk("B_b5", 5, 9'h001);
    cap_chk("B_b7", 7, 9'h002);   cap_chk("B_b1023", 1023, 9'h1FE);
    cap_chk("B_b1022", 1022, 9'h001);

    // stall until the FIFO overflows, then drain
    do_reset();
    tr_mode = 0; hr_mode = 0; tv_mode = 1;
    repeat (1100) @(posedge clk);
    #1;
    check("C_overflow_set", fifo_overflow, 1);
    check("C_busy_stalled", busy, 1);
    #1 tr_mode = 1; tv_mode = 3;
    wait_pkt(2, 5000, "C_drain");
    check("C_overflow_sticky", fifo_overflow, 1);
    cap_chk("C_p2_s0_hi", 1026, 9'h001); cap_chk("C_p2_s0_lo", 1027, 9'h0FF);
    cap_chk("C_p1_last", 1023, 9'h1FE); cap_chk("C_p2_last", 2047, 9'h1FD);
    tlast_total("C_tlast_count", 2);

    // reset in the middle of a payload
    do_reset();
    tr_mode = 1; tv_mode = 3;
    wait_byte(300, 0, "D_reach_byte300", 5000);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("D_rst_hdr_valid", bus.m_udp_hdr_valid, 0);
    check("D_rst_tvalid", bus.m_udp_payload_axis_tvalid, 0);
    check("D_rst_tlast", bus.m_udp_payload_axis_tlast, 0);
    check("D_rst_tdata", bus.m_udp_payload_axis_tdata, 0);
    check("D_rst_busy", busy, 0);
    check("D_rst_overflow", fifo_overflow, 0);
    tlast_total("D_no_tlast", 0);
    tv_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    ramp = 0; cap_q.delete(); rst_n = 1'b1; tv_mode = 3;
    wait_pkt(1, 5000, "D_after_reset");
    cap_chk("D_seq_hi", 0, 9'h000); cap_chk("D_seq_lo", 1, 9'h000);
    cap_chk("D_s0_lo", 3, 9'h000);  cap_chk("D_last", 1023, 9'h1FE);

    // enable dropped mid-packet
    wait_byte(500, 1, "E_reach_byte500", 5000);
    @(posedge clk); #2;
    enable = 1'b0;
    wait_pkt(2, 3000, "E_completes");
    cap_chk("E_tlast", 2047, 9'h1FD);
    hv = 0;
    repeat (300) begin @(posedge clk); #1; if (bus.m_udp_hdr_valid) hv++; end
    check("E_no_hdr_disabled", hv, 0);
    check("E_idle_busy", busy, 0);
    #1 enable = 1'b1;
    hv = 0;
    while (!bus.m_udp_hdr_valid && hv < 3000) begin @(posedge clk); #1; hv++; end
    check("E_hdr_after_enable", bus.m_udp_hdr_valid, 1);
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/adc_udp_packetizer.md
ADC_UDP_PACKETIZER -- requirements
Module: adc_udp_packetizer

Interface
REQ-001 SHALL have parameter SAMPLES_PER_PKT, default 511, giving 16-bit samples per UDP payload (payload bytes = 2 + 2*SAMPLES_PER_PKT = 1024).
REQ-002 SHALL have parameter FIFO_ADDR_WIDTH, default 10, giving sample FIFO depth 2**FIFO_ADDR_WIDTH; must hold at least SAMPLES_PER_PKT + 1 samples.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: logic_clk  in  1  sole clock, all logic rising-edge; logic_rst_n  in  1  asynchronous active-low reset.
REQ-004 enable  in  1  permits sample capture and packet starts.
REQ-005 adc_tdata  in  16  ADC sample; adc_tvalid  in  1  sample strobe (no backpressure).
REQ-006 m_udp_hdr_valid  out  1 / m_udp_hdr_ready  in  1  header handshake toward UDP transmitter.
REQ-007 m_udp_payload_axis_tdata  out  8; _tvalid  out  1; _tready  in  1; _tlast  out  1; _tuser  out  1  AXI-Stream payload, byte-wide.
REQ-008 fifo_overflow  out  1  sticky sample-drop flag; pkt_count  out  32  packets completed; busy  out  1  high when FSM not IDLE.

Function
REQ-009 SHALL write adc_tdata into FIFO when adc_tvalid && enable && FIFO not full.
REQ-010 SHALL drop the sample and set fifo_overflow when adc_tvalid && enable && FIFO full and no pop in the same cycle; push with simultaneous pop at full SHALL be accepted.
REQ-011 FSM states SHALL be IDLE, HDR, SEQ_HI, SEQ_LO, DATA_HI, DATA_LO.
REQ-012 IDLE->HDR SHALL occur on the edge where enable=1 and FIFO count >= SAMPLES_PER_PKT; a full packet SHALL be buffered before start so the payload never stalls on input.
REQ-013 In HDR, m_udp_hdr_valid SHALL be 1 and held until m_udp_hdr_ready; on handshake -> SEQ_HI.
REQ-014 In SEQ_HI/SEQ_LO/DATA_HI/DATA_LO, tvalid SHALL be 1 continuously; state advances only on tvalid && tready; tdata held stable while stalled.
REQ-015 Byte order SHALL be MSB first: SEQ_HI=seq[15:8], SEQ_LO=seq[7:0], DATA_HI=sample[15:8], DATA_LO=sample[7:0].
REQ-016 FIFO pop SHALL occur on the DATA_LO byte handshake; DATA_LO->DATA_HI until the last sample.
REQ-017 tlast SHALL be 1 only on DATA_LO of sample SAMPLES_PER_PKT; on its handshake -> IDLE, seq increments, pkt_count increments.
REQ-018 seq SHALL be 16 bits, wrap 0xFFFF->0x0000; pkt_count SHALL wrap 2**32-1->0.
REQ-019 tuser SHALL be constant 0.
REQ-020 enable deassert mid-packet SHALL NOT abort the packet; FIFO contents SHALL be retained; no new packet starts while enable=0.
REQ-021 tvalid SHALL be 0 in IDLE and HDR; hdr_valid SHALL be 0 outside HDR.

Reset
REQ-022 On logic_rst_n=0, asynchronously: FSM=IDLE, FIFO empty, seq=0, pkt_count=0, fifo_overflow=0, all valid/last/user outputs 0, tdata 0, busy 0.
REQ-023 Reset mid-packet SHALL abandon the packet without emitting tlast; operation resumes from the REQ-012 condition after release.
REQ-024 Reset release SHALL be synchronised to logic_clk by the instantiating level; fifo_overflow clears only on reset.

Structure
REQ-025 Shared package eth_pkg SHALL hold the FSM state enum, UDP_PAYLOAD_BYTES=1024 and UDP_LENGTH=16'h0408.
REQ-026 Sample storage SHALL be a sub-module sample_fifo: synchronous, first-word-fall-through, 16-bit, exposing count, full, empty.

Verification
REQ-027 Ramp 0x0000.. at adc_tvalid=1, enable=1, tready=1, hdr_ready=1 -> one header, then 1024 bytes 00 00 00 00 00 01 ... 01 FE, tlast on byte 1024 only, pkt_count=1.
REQ-028 Three back-to-back packets -> seq bytes 0x0000, 0x0001, 0x0002; samples contiguous across packets; no gaps.
REQ-029 tready toggled pseudo-randomly 50%, hdr_ready delayed 5 cycles -> byte stream identical to REQ-027, tdata stable while stalled.
REQ-030 tready=0 with continuous samples until FIFO full -> fifo_overflow=1 on first drop, sticky; stream resumes with samples after the gap, no tlast corruption.
REQ-031 Reset asserted at payload byte 300 -> all outputs 0 same cycle, seq=0, next packet after release starts with seq 0x0000.
REQ-032 enable dropped at payload byte 500 -> packet completes with tlast; no further hdr_valid until enable=1.
